count_sequencer: RTL and testbench
==================================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset; highest priority.
REQ-004 start  input  1  request to begin a counting run; sampled only in IDLE.
REQ-005 stop  input  1  abort the run and return to IDLE; sampled in any state.
REQ-006 pause  input  1  hold the count while high; sampled in RUN and PAUSE.
REQ-007 mod_sel  input  3  terminal count latched at start; count runs 0..mod_sel, so the modulus is mod_sel+1.
REQ-008 wrap_target  input  4  number of wraps latched at start; 0 means free-run with no DONE.
REQ-009 count  output  3  current count value, registered.
REQ-010 wrap  output  1  one-cycle registered pulse, high in the cycle count shows 0 after a wrap.
REQ-011 toggle_out  output  1  registered; inverts on every wrap.
REQ-012 wrap_count  output  4  number of wraps since the last accepted start, registered.
REQ-013 busy  output  1  high when the state is RUN or PAUSE.
REQ-014 done  output  1  one-cycle pulse, high while the state is DONE.

Function
REQ-015 The block SHALL implement the states IDLE, RUN, PAUSE and DONE.
REQ-016 Priority on every edge SHALL be: reset, then stop, then pause, then increment/start.
REQ-017 IDLE: start=1 and stop=0 SHALL do all of the following on the same edge:
- latch mod_sel and wrap_target;
- clear count and wrap_count to 0;
- move to RUN.
REQ-018 IDLE: with no start, count, wrap_count and toggle_out SHALL hold their values.
REQ-019 start SHALL be ignored in RUN, PAUSE and DONE; the latched mod_sel and wrap_target SHALL NOT change mid-run.
REQ-020 RUN with pause=0 and count below the latched mod_sel: count SHALL increase by 1 per cycle. The first increment occurs on the first edge the block spends in RUN.
REQ-021 RUN with pause=0 and count equal to the latched mod_sel: the wrap edge SHALL do all of the following:
- set count to 0;
- assert wrap for one cycle;
- invert toggle_out;
- increment wrap_count by 1, modulo 16.
REQ-022 Latched mod_sel=0: count SHALL stay 0 and a wrap SHALL occur on every RUN cycle.
REQ-023 On a wrap edge where the latched target is nonzero and wrap_count+1 equals the target, the next state SHALL be DONE; otherwise it stays RUN.
REQ-024 Latched target=0: the block SHALL stay in RUN indefinitely, and wrap_count SHALL roll over from 15 to 0.
REQ-025 RUN with pause=1: the next state SHALL be PAUSE, with no increment and no wrap on that edge.
REQ-026 PAUSE: count, wrap_count and toggle_out SHALL hold. pause=0 returns to RUN, and counting resumes on the following edge.
REQ-027 DONE SHALL last exactly one cycle, with done=1 and busy=0, then go to IDLE. count (0), wrap_count and toggle_out SHALL hold through DONE and the following IDLE.
REQ-028 stop=1 in RUN, PAUSE or DONE SHALL do all of the following:
- set the next state to IDLE;
- clear count to 0;
- not assert wrap or done, even if the count is at terminal;
- leave wrap_count and toggle_out holding.
REQ-029 stop=1 and start=1 together in IDLE: the block SHALL remain in IDLE and ignore start.
REQ-030 wrap and done SHALL never be high for two consecutive cycles of one event. A DONE-entering wrap gives wrap high in the DONE cycle.

Reset
REQ-031 reset=1 SHALL force the following on the next edge, from any state including mid-run, with no wrap or done pulse:
- state: IDLE;
- count: 0;
- wrap_count: 0;
- toggle_out: 0;
- wrap, done, busy: 0;
- latched mod_sel: 0;
- latched wrap_target: 0.
REQ-032 The block SHALL apply no asynchronous reset path; every output SHALL be registered or decoded from the registered state.

Verification
REQ-033 Modulo-6 run: mod_sel=5, wrap_target=2, start pulse -> the bench SHALL see:
- count 1,2,3,4,5,0,1..5,0;
- wrap pulses on both returns to 0;
- toggle_out 0->1->0;
- done high in the cycle of the second wrap, then busy=0.
REQ-034 Pause mid-run: mod_sel=7, pause high for 3 cycles when count=3 -> count holds 3 for those cycles, busy stays 1, and the count then resumes 4,5,6,7,0.
REQ-035 Stop at terminal: mod_sel=4, stop asserted when count=4 -> next cycle IDLE, count=0, wrap=0, toggle_out unchanged.
REQ-036 Free-run: mod_sel=0, wrap_target=0 -> wrap every cycle, wrap_count 0..15 then 0, toggle_out alternates, done never asserted.
REQ-037 Reset mid-run: mod_sel=6, wrap_target=3, reset asserted with wrap_count=1 and count=4 -> all outputs 0 after the edge. start while busy is ignored; mod_sel changes mid-run have no effect.
REQ-038 start and stop in the same IDLE cycle -> the block stays IDLE with busy=0 and count=0.

Source files
------------

// File: rtl/count_sequencer_if.sv
// Control and status bundle for count_sequencer.
// master drives the run controls and observes the status; slave is the sequencer side.
interface count_sequencer_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic [2:0] mod_sel;
  logic [3:0] wrap_target;
  logic [2:0] count;
  logic       wrap;
  logic       toggle_out;
  logic [3:0] wrap_count;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, pause, mod_sel, wrap_target,
    input  count, wrap, toggle_out, wrap_count, busy, done
  );

  modport slave (
    input  start, stop, pause, mod_sel, wrap_target,
    output count, wrap, toggle_out, wrap_count, busy, done
  );
endinterface

// File: rtl/count_sequencer.sv
// Modulo counter sequencer: counts 0..mod_sel, pulses wrap on each return to 0,
// and finishes after wrap_target wraps (wrap_target=0 runs until stopped).
module count_sequencer (
  input logic                 clk,
  input logic                 reset,
  count_sequencer_if.slave    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] r_state;
  logic [2:0] r_count;
  logic       r_wrap;
  logic       r_toggle;
  logic [3:0] r_wrap_count;
  logic [2:0] r_mod;
  logic [3:0] r_target;

  logic       w_at_term;
  logic [3:0] w_wc_inc;
  logic       w_hit_target;

  // Terminal-count and target-reached decodes for the wrap edge
  always_comb begin
    w_at_term    = (r_count == r_mod);
    w_wc_inc     = r_wrap_count + 4'd1;
    w_hit_target = (r_target != '0) && (w_wc_inc == r_target);
  end

  // State, count and wrap bookkeeping; reset > stop > pause > increment/start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_wrap       <= 1'b0;
      r_toggle     <= 1'b0;
      r_wrap_count <= '0;
      r_mod        <= '0;
      r_target     <= '0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            r_mod        <= bus.mod_sel;
            r_target     <= bus.wrap_target;
            r_count      <= '0;
            r_wrap_count <= '0;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            r_count <= '0;
            r_state <= S_IDLE;
          end else if (bus.pause) begin
            r_state <= S_PAUSE;
          end else if (w_at_term) begin
            r_count      <= '0;
            r_wrap       <= 1'b1;
            r_toggle     <= ~r_toggle;
            r_wrap_count <= w_wc_inc;
            r_state      <= w_hit_target ? S_DONE : S_RUN;
          end else begin
            r_count <= r_count + 3'd1;
          end
        end
        S_PAUSE: begin
          if (bus.stop) begin
            r_count <= '0;
            r_state <= S_IDLE;
          end else if (!bus.pause) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          // DONE lasts one cycle; count is already 0, stop changes nothing here
          r_count <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.count      = r_count;
  assign bus.wrap       = r_wrap;
  assign bus.toggle_out = r_toggle;
  assign bus.wrap_count = r_wrap_count;
  assign bus.busy       = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign bus.done       = (r_state == S_DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios plus random
// stimulus, all compared against a behavioural model of the sequencer.
module tb_count_sequencer;

  logic clk;
  logic rst;
  count_sequencer_if bus();

  count_sequencer dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Behavioural model: phase is one of idle/run/pause/done
  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_PAUSE = 2;
  localparam int PH_DONE  = 3;

  int m_phase;
  int m_count;
  int m_mod;
  int m_target;
  int m_wc;
  bit m_wrap;
  bit m_tog;

  function automatic logic [10:0] exp_vec();
    bit busy = (m_phase == PH_RUN) || (m_phase == PH_PAUSE);
    bit done = (m_phase == PH_DONE);
    return {3'(m_count), m_wrap, m_tog, 4'(m_wc), busy, done};
  endfunction

  function automatic logic [10:0] act_vec();
    return {bus.count, bus.wrap, bus.toggle_out, bus.wrap_count, bus.busy, bus.done};
  endfunction

  // Advance one clock edge and update the model from the inputs present at that edge
  task automatic tick();
    bit s  = bus.start;
    bit st = bus.stop;
    bit p  = bus.pause;
    bit r  = rst;
    int ms = int'(bus.mod_sel);
    int wt = int'(bus.wrap_target);
    @(posedge clk);
    m_wrap = 1'b0;
    if (r) begin
      m_phase = PH_IDLE; m_count = 0; m_wc = 0; m_tog = 1'b0; m_mod = 0; m_target = 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (s && !st) begin
          m_mod = ms; m_target = wt; m_count = 0; m_wc = 0; m_phase = PH_RUN;
        end
        PH_RUN: begin
          if (st) begin
            m_count = 0; m_phase = PH_IDLE;
          end else if (p) begin
            m_phase = PH_PAUSE;
          end else begin
            m_count = (m_count + 1) % (m_mod + 1);
            if (m_count == 0) begin
              m_wrap = 1'b1;
              m_tog  = ~m_tog;
              m_wc   = (m_wc + 1) % 16;
              if (m_target != 0 && m_wc == m_target) m_phase = PH_DONE;
            end
          end
        end
        PH_PAUSE: begin
          if (st) begin
            m_count = 0; m_phase = PH_IDLE;
          end else if (!p) begin
            m_phase = PH_RUN;
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
    #1;
  endtask

  task automatic drive(bit s, bit st, bit p, logic [2:0] ms, logic [3:0] wt);
    bus.start = s; bus.stop = st; bus.pause = p; bus.mod_sel = ms; bus.wrap_target = wt;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 3'd0, 4'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (act_vec() !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %b expected %b", act_vec(), 11'd0);
    end
    tick();
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL reset_idle_hold: got %b expected %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_modulo6();
    int seq [12] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    bit tog0;
    tog0 = bus.toggle_out;
    drive(1, 0, 0, 3'd5, 4'd2);
    tick();
    drive(0, 0, 0, 3'd5, 4'd2);
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL mod6_model cyc%0d: got %b expected %b", i, act_vec(), exp_vec());
      end
      n_checks++;
      if (int'(bus.count) !== seq[i] || bus.wrap !== (i == 5 || i == 11)
          || bus.done !== (i == 11) || bus.toggle_out !== (tog0 ^ (i >= 5 && i < 11))) begin
        n_errors++;
        $display("FAIL mod6_seq cyc%0d: count=%0d wrap=%b done=%b tog=%b expected count=%0d",
                 i, bus.count, bus.wrap, bus.done, bus.toggle_out, seq[i]);
      end
    end
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wrap_count !== 4'd2) begin
      n_errors++;
      $display("FAIL mod6_after_done: busy=%b done=%b wc=%0d expected busy=0 done=0 wc=2",
               bus.busy, bus.done, bus.wrap_count);
    end
  endtask

  task automatic test_pause();
    int resume [5] = '{4, 5, 6, 7, 0};
    drive(1, 0, 0, 3'd7, 4'd0);
    tick();
    drive(0, 0, 0, 3'd7, 4'd0);
    repeat (3) tick();
    drive(0, 0, 1, 3'd7, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.count !== 3'd3 || bus.busy !== 1'b1 || act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL pause_hold cyc%0d: got %b expected %b (count 3, busy 1)", i, act_vec(), exp_vec());
      end
    end
    drive(0, 0, 0, 3'd7, 4'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (int'(bus.count) !== resume[i] || act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL pause_resume cyc%0d: count=%0d expected %0d", i, bus.count, resume[i]);
      end
    end
    drive(0, 1, 0, 3'd0, 4'd0);
    tick();
    drive(0, 0, 0, 3'd0, 4'd0);
  endtask

  task automatic test_stop_terminal();
    bit tog0;
    drive(1, 0, 0, 3'd4, 4'd0);
    tick();
    drive(0, 0, 0, 3'd4, 4'd0);
    repeat (4) tick();
    tog0 = bus.toggle_out;
    n_checks++;
    if (bus.count !== 3'd4) begin
      n_errors++;
      $display("FAIL stop_setup: count=%0d expected 4", bus.count);
    end
    drive(0, 1, 0, 3'd4, 4'd0);
    tick();
    drive(0, 0, 0, 3'd4, 4'd0);
    n_checks++;
    if (bus.count !== 3'd0 || bus.wrap !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0
        || bus.toggle_out !== tog0 || act_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL stop_terminal: got %b expected %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_free_run();
    drive(1, 0, 0, 3'd0, 4'd0);
    tick();
    drive(0, 0, 0, 3'd0, 4'd0);
    for (int i = 1; i <= 18; i++) begin
      tick();
      n_checks++;
      if (bus.wrap !== 1'b1 || bus.done !== 1'b0 || int'(bus.wrap_count) !== (i % 16)
          || act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL free_run cyc%0d: got %b expected %b wc=%0d", i, act_vec(), exp_vec(), i % 16);
      end
    end
    drive(0, 1, 0, 3'd0, 4'd0);
    tick();
    drive(0, 0, 0, 3'd0, 4'd0);
  endtask

  task automatic test_reset_midrun();
    drive(1, 0, 0, 3'd6, 4'd3);
    tick();
    // start and a different mod_sel mid-run must both be ignored
    drive(1, 0, 0, 3'd2, 4'd1);
    repeat (11) tick();
    n_checks++;
    if (bus.wrap_count !== 4'd1 || bus.count !== 3'd4 || bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL midrun_setup: wc=%0d count=%0d busy=%b expected wc=1 count=4 busy=1",
               bus.wrap_count, bus.count, bus.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 3'd0, 4'd0);
    n_checks++;
    if (act_vec() !== 11'd0) begin
      n_errors++;
      $display("FAIL midrun_reset: got %b expected %b", act_vec(), 11'd0);
    end
  endtask

  task automatic test_start_stop();
    drive(1, 1, 0, 3'd3, 4'd1);
    tick();
    drive(0, 0, 0, 3'd3, 4'd1);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.count !== 3'd0 || act_vec() !== exp_vec()) begin
      n_errors++;
      $display("FAIL start_stop: got %b expected %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(3) == 0), ($urandom_range(15) == 0), ($urandom_range(4) == 0),
            3'($urandom_range(7)), 4'($urandom_range(3)));
      rst = ($urandom_range(63) == 0);
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL random cyc%0d: got %b expected %b", i, act_vec(), exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_phase = PH_IDLE; m_count = 0; m_mod = 0; m_target = 0; m_wc = 0; m_wrap = 0; m_tog = 0;
    rst = 1'b1;
    drive(0, 0, 0, 3'd0, 4'd0);
    @(negedge clk);
    test_reset();
    test_modulo6();
    test_pause();
    test_stop_terminal();
    test_free_run();
    test_reset_midrun();
    test_start_stop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
